// File: rtl/simon_pkg.sv
// Shared definitions for the Simon cipher blocks: word sizes, z constant
// sequences, FSM state encoding and the round limit.
package simon_pkg;

    // Largest round count any Simon configuration uses (Simon128/256).
    localparam int MAX_ROUNDS = 72;

    // Length of one z constant sequence.
    localparam int Z_LEN = 62;

    // z constant sequences z0..z4, written left to right so that bit
    // [Z_LEN-1] holds z[0] and bit [0] holds z[61].
    localparam logic [Z_LEN-1:0] Z_SEQ [0:4] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    // States of the encryption round controller.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Word size N in bits for a block-size index 0..4.
    function automatic int word_size(input int blk_size_ind);
        case (blk_size_ind)
            0:       return 16;
            1:       return 24;
            2:       return 32;
            3:       return 48;
            default: return 64;
        endcase
    endfunction

    // Element idx (0 = first) of z sequence seq.
    function automatic logic z_bit(input logic [2:0] seq, input int unsigned idx);
        logic [Z_LEN-1:0] z;
        logic [Z_LEN-1:0] shifted;
        z       = Z_SEQ[seq];
        shifted = z >> (Z_LEN - 1 - int'(idx % Z_LEN));
        return shifted[0];
    endfunction

endpackage

// File: rtl/simon_round_fn.sv
// Combinational Simon Feistel round on N-bit words.
// x_n = y ^ ((x <<< 1) & (x <<< 8)) ^ (x <<< 2) ^ k, y_n = x.
// Shared between the encryptor and a future decryptor.
module simon_round_fn
    import simon_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] k,
    output logic [N-1:0] x_n,
    output logic [N-1:0] y_n
);

    logic [N-1:0] rot1;
    logic [N-1:0] rot2;
    logic [N-1:0] rot8;
    logic [N-1:0] f;

    // Left rotations stay inside the N-bit word.
    assign rot1 = {x[N-2:0], x[N-1]};
    assign rot2 = {x[N-3:0], x[N-1:N-2]};
    assign rot8 = {x[N-9:0], x[N-1:N-8]};

    assign f   = (rot1 & rot8) ^ rot2;
    assign x_n = y ^ f ^ k;
    assign y_n = x;

endmodule

// File: rtl/simon_enc_round.sv
// Simon encryption datapath: takes one plaintext block, applies one Feistel
// round per accepted round key from the subkey generator, then offers the
// ciphertext on a valid/ready output. One block in flight at a time.
// Optional build macro: SIMON_ENC_ROUND_PERF_EN adds the blk_cnt output
// counting completed ciphertext handshakes.
module simon_enc_round
    import simon_pkg::*;
#(
    parameter int BLK_SIZE_IND = 0,
    parameter int NUM_ROUNDS   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] pt_in,
    input  logic         pt_in_vld,
    output logic         pt_in_rdy,
    input  logic [255:0] subkey_in,
    input  logic         subkey_in_vld,
    output logic         subkey_in_rdy,
    output logic [127:0] ct_out,
    output logic         ct_out_vld,
    input  logic         ct_out_rdy
`ifdef SIMON_ENC_ROUND_PERF_EN
    ,
    output logic [31:0]  blk_cnt
`endif
);

    localparam int N     = word_size(BLK_SIZE_IND);
    localparam int CNT_W = $clog2(MAX_ROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

    state_t           state;
    state_t           state_n;
    logic [N-1:0]     x;
    logic [N-1:0]     y;
    logic [N-1:0]     x_n;
    logic [N-1:0]     y_n;
    logic [CNT_W-1:0] round_cnt;
    logic             pt_hs;
    logic             key_hs;
    logic             unused_bits;

    // Bits above the active block and key width are deliberately ignored.
    assign unused_bits = ^{pt_in, subkey_in};

    assign pt_hs  = pt_in_vld & pt_in_rdy;
    assign key_hs = subkey_in_vld & subkey_in_rdy;

    simon_round_fn #(
        .N (N)
    ) u_round (
        .x   (x),
        .y   (y),
        .k   (subkey_in[N-1:0]),
        .x_n (x_n),
        .y_n (y_n)
    );

    // Controller state register; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake outputs; ready/valid depend only on the state
    // so keys offered in IDLE or DONE stall upstream.
    always_comb begin
        state_n       = state;
        pt_in_rdy     = 1'b0;
        subkey_in_rdy = 1'b0;
        ct_out_vld    = 1'b0;
        ct_out        = '0;
        unique case (state)
            IDLE: begin
                pt_in_rdy = 1'b1;
                if (pt_in_vld) begin
                    state_n = ROUND;
                end
            end
            ROUND: begin
                subkey_in_rdy = 1'b1;
                if (subkey_in_vld && (round_cnt == LAST_ROUND)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                ct_out_vld           = 1'b1;
                ct_out[2*N-1:0]      = {x, y};
                if (ct_out_rdy) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Cipher state: load on plaintext acceptance, one round per accepted key.
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            round_cnt <= '0;
        end else if (pt_hs) begin
            x         <= pt_in[2*N-1:N];
            y         <= pt_in[N-1:0];
            round_cnt <= '0;
        end else if (key_hs) begin
            x         <= x_n;
            y         <= y_n;
            round_cnt <= round_cnt + CNT_W'(1);
        end
    end

`ifdef SIMON_ENC_ROUND_PERF_EN
    logic ct_hs;

    assign ct_hs = ct_out_vld & ct_out_rdy;

    // Free-running count of delivered ciphertext blocks, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= '0;
        end else if (ct_hs) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simon_enc_round.sv
// Directed bench for simon_enc_round: Simon32/64 and Simon64/128 instances,
// published test vectors, stalls, mid-block reset and back-to-back blocks.
module tb_simon_enc_round;

    logic clk = 1'b0;
    logic rst;

    // Index 0: Simon32/64 instance, index 1: Simon64/128 instance.
    logic [127:0] pt_in         [2];
    logic         pt_in_vld     [2];
    logic         pt_in_rdy     [2];
    logic [255:0] subkey_in     [2];
    logic         subkey_in_vld [2];
    logic         subkey_in_rdy [2];
    logic [127:0] ct_out        [2];
    logic         ct_out_vld    [2];
    logic         ct_out_rdy    [2];
`ifdef SIMON_ENC_ROUND_PERF_EN
    logic [31:0]  blk_cnt       [2];
`endif

    int          compared   = 0;
    int          mismatched = 0;
    int          word_n [2] = '{16, 32};
    int          rounds [2] = '{32, 44};
    logic [63:0] rk     [2][72];
    int          kidx   [2];
    int          viol;
    int          lat;
    int          guard;

    localparam string Z0 = "11111010001001010110000111001101111101000100101011000011100110";
    localparam string Z3 = "11011011101011000110010111100000010010001010011100110100001111";

    always #5 clk = ~clk;

    simon_enc_round #(.BLK_SIZE_IND(0), .NUM_ROUNDS(32)) dut0 (
        .clk           (clk),
        .rst           (rst),
        .pt_in         (pt_in[0]),
        .pt_in_vld     (pt_in_vld[0]),
        .pt_in_rdy     (pt_in_rdy[0]),
        .subkey_in     (subkey_in[0]),
        .subkey_in_vld (subkey_in_vld[0]),
        .subkey_in_rdy (subkey_in_rdy[0]),
        .ct_out        (ct_out[0]),
        .ct_out_vld    (ct_out_vld[0]),
        .ct_out_rdy    (ct_out_rdy[0])
`ifdef SIMON_ENC_ROUND_PERF_EN
        ,
        .blk_cnt       (blk_cnt[0])
`endif
    );

    simon_enc_round #(.BLK_SIZE_IND(2), .NUM_ROUNDS(44)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .pt_in         (pt_in[1]),
        .pt_in_vld     (pt_in_vld[1]),
        .pt_in_rdy     (pt_in_rdy[1]),
        .subkey_in     (subkey_in[1]),
        .subkey_in_vld (subkey_in_vld[1]),
        .subkey_in_rdy (subkey_in_rdy[1]),
        .ct_out        (ct_out[1]),
        .ct_out_vld    (ct_out_vld[1]),
        .ct_out_rdy    (ct_out_rdy[1])
`ifdef SIMON_ENC_ROUND_PERF_EN
        ,
        .blk_cnt       (blk_cnt[1])
`endif
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_mask(input int n);
        return (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] v, input int r, input int n);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < n; i++) o[(i + r) % n] = v[i];
        return o;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int r, input int n);
        return rotl(v, n - r, n);
    endfunction

    // Four-word Simon key schedule (m = 4) with the given z sequence.
    task automatic gen_keys(input int sel, input logic [63:0] k0, input logic [63:0] k1,
                            input logic [63:0] k2, input logic [63:0] k3, input string zs);
        int          n;
        logic [63:0] m;
        logic [63:0] tmp;
        logic [63:0] zb;
        n = word_n[sel];
        m = word_mask(n);
        rk[sel][0] = k0; rk[sel][1] = k1; rk[sel][2] = k2; rk[sel][3] = k3;
        for (int i = 4; i < rounds[sel]; i++) begin
            tmp = rotr(rk[sel][i-1], 3, n) ^ rk[sel][i-3];
            tmp = tmp ^ rotr(tmp, 1, n);
            zb  = (zs[(i - 4) % 62] == "1") ? 64'd1 : 64'd0;
            rk[sel][i] = (m & ~64'd3) ^ zb ^ rk[sel][i-4] ^ tmp;
        end
    endtask

    function automatic logic [127:0] model_enc(input int sel, input logic [127:0] pt);
        int          n;
        logic [63:0] m;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] t;
        n = word_n[sel];
        m = word_mask(n);
        x = 64'(pt >> n) & m;
        y = 64'(pt) & m;
        for (int r = 0; r < rounds[sel]; r++) begin
            t = x;
            x = y ^ (rotl(x, 1, n) & rotl(x, 8, n)) ^ rotl(x, 2, n) ^ rk[sel][r];
            y = t;
        end
        return (128'(x) << n) | 128'(y);
    endfunction

    // Present the current round key with random junk above the key word.
    task automatic drive_key(input int sel, input bit on);
        logic [255:0] junk;
        logic [255:0] m;
        junk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        m    = (256'd1 << word_n[sel]) - 256'd1;
        subkey_in_vld[sel] = on;
        subkey_in[sel]     = (junk & ~m) | 256'(rk[sel][kidx[sel]]);
    endtask

    // Advance one clock (negedge to negedge), tracking accepted keys.
    task automatic tick(input int sel);
        bit hs;
        hs = (subkey_in_vld[sel] === 1'b1) && (subkey_in_rdy[sel] === 1'b1);
        @(posedge clk);
        if (hs) kidx[sel] = (kidx[sel] + 1) % rounds[sel];
        @(negedge clk);
    endtask

    // Encrypt one block: gap > 0 drops key valid at random, stall holds
    // ct_out_rdy low for that many DONE cycles. Returns the latency in
    // cycles counted from the plaintext handshake cycle.
    task automatic applyStimulus(input int sel, input logic [127:0] pt, input int gap,
                                 input int stall, input logic [127:0] exp,
                                 input string tag, output int latency);
        int           cyc;
        logic [127:0] held;
        viol = 0;
        cyc  = 0;
        ct_out_rdy[sel] = 1'b0;
        while (pt_in_rdy[sel] !== 1'b1 && cyc < 100) begin
            drive_key(sel, 1'b1);
            tick(sel);
            cyc++;
        end
        if (subkey_in_rdy[sel] !== 1'b0) viol++;
        pt_in[sel]     = pt;
        pt_in_vld[sel] = 1'b1;
        drive_key(sel, 1'b1);
        tick(sel);
        pt_in_vld[sel] = 1'b0;
        pt_in[sel]     = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        while (ct_out_vld[sel] !== 1'b1 && cyc < 400) begin
            if (pt_in_rdy[sel] !== 1'b0) viol++;
            drive_key(sel, (gap == 0) || ($urandom_range(0, gap) != 0));
            tick(sel);
            cyc++;
        end
        latency = cyc;
        held = ct_out[sel];
        for (int s = 0; s < stall; s++) begin
            if (ct_out[sel] !== held || ct_out_vld[sel] !== 1'b1) viol++;
            if (pt_in_rdy[sel] !== 1'b0 || subkey_in_rdy[sel] !== 1'b0) viol++;
            drive_key(sel, 1'b1);
            tick(sel);
        end
        checkOutput({tag, ".ct"}, ct_out[sel], exp);
        if (subkey_in_rdy[sel] !== 1'b0 || pt_in_rdy[sel] !== 1'b0) viol++;
        ct_out_rdy[sel] = 1'b1;
        drive_key(sel, 1'b1);
        tick(sel);
        ct_out_rdy[sel] = 1'b0;
        checkOutput({tag, ".rdy_viol"}, 128'(viol), 128'd0);
        checkOutput({tag, ".idle_after"}, {126'd0, ct_out_vld[sel], pt_in_rdy[sel]}, 128'b01);
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            pt_in[s]         = '0;
            pt_in_vld[s]     = 1'b0;
            subkey_in[s]     = '0;
            subkey_in_vld[s] = 1'b0;
            ct_out_rdy[s]    = 1'b0;
            kidx[s]          = 0;
        end
        gen_keys(0, 64'h0100, 64'h0908, 64'h1110, 64'h1918, Z0);
        gen_keys(1, 64'h03020100, 64'h0b0a0908, 64'h13121110, 64'h1b1a1918, Z3);

        // Reset values on both instances.
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("reset%0d.ready", s),
                        {126'd0, pt_in_rdy[s], subkey_in_rdy[s]}, 128'b10);
            checkOutput($sformatf("reset%0d.ct_vld", s), {127'd0, ct_out_vld[s]}, 128'd0);
            checkOutput($sformatf("reset%0d.ct_out", s), ct_out[s], 128'd0);
        end
`ifdef SIMON_ENC_ROUND_PERF_EN
        checkOutput("reset.blk_cnt", 128'(blk_cnt[0]), 128'd0);
`endif
        rst = 1'b0;

        // Three back-to-back Simon32/64 blocks, keys valid every cycle.
        applyStimulus(0, 128'h65656877, 0, 0, 128'hc69be9bb, "b2b0", lat);
        checkOutput("b2b0.latency", 128'(lat), 128'd33);
        applyStimulus(0, 128'h12345678, 0, 0, model_enc(0, 128'h12345678), "b2b1", lat);
        applyStimulus(0, 128'h0badcafe, 0, 0, model_enc(0, 128'h0badcafe), "b2b2", lat);
        checkOutput("b2b2.latency", 128'(lat), 128'd33);
        checkOutput("b2b.key_align", 128'(kidx[0]), 128'd0);
`ifdef SIMON_ENC_ROUND_PERF_EN
        checkOutput("perf.three", 128'(blk_cnt[0]), 128'd3);
`endif

        // Random key gaps, junk in upper plaintext bits, 10-cycle ct stall.
        applyStimulus(0, {96'hdeadbeef_a5a5a5a5_0f0f0f0f, 32'h65656877}, 3, 10,
                      128'hc69be9bb, "gaps", lat);
        checkOutput("gaps.latency_min", 128'(lat >= 33), 128'd1);

        // Reset after the fifth accepted key of a block.
        pt_in[0]     = 128'h65656877;
        pt_in_vld[0] = 1'b1;
        drive_key(0, 1'b1);
        tick(0);
        pt_in_vld[0] = 1'b0;
        guard = 0;
        while (kidx[0] < 5 && guard < 50) begin
            drive_key(0, 1'b1);
            tick(0);
            guard++;
        end
        checkOutput("rstmid.in_round", {126'd0, subkey_in_rdy[0], pt_in_rdy[0]}, 128'b10);
        rst = 1'b1;
        subkey_in_vld[0] = 1'b0;
        tick(0);
        checkOutput("rstmid.ready", {126'd0, pt_in_rdy[0], subkey_in_rdy[0]}, 128'b10);
        checkOutput("rstmid.ct_vld", {127'd0, ct_out_vld[0]}, 128'd0);
        checkOutput("rstmid.ct_out", ct_out[0], 128'd0);
`ifdef SIMON_ENC_ROUND_PERF_EN
        checkOutput("rstmid.blk_cnt", 128'(blk_cnt[0]), 128'd0);
`endif
        rst     = 1'b0;
        kidx[0] = 0;
        applyStimulus(0, 128'h65656877, 0, 0, 128'hc69be9bb, "post_rst", lat);
        checkOutput("post_rst.latency", 128'(lat), 128'd33);

        // Simon64/128 published vector.
        applyStimulus(1, 128'h656b696c_20646e75, 0, 0, 128'h44c8fc20_b9dfa07a, "s64", lat);
        checkOutput("s64.latency", 128'(lat), 128'd45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
